// File: rtl/uart_bridge_rx_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared types and constants for the UART command-stream bridge.
//   - state_t       : parser states (IDLE, ADDR, DATA, TERM)
//   - CHAR_*        : ASCII codes of command letters and terminators
//   - BUS_ADDR_W/_W : width of the bus address and data fields
//   - is_term()     : true for CR or LF
// -----------------------------------------------------------------------------
package bridge_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  localparam logic [7:0] CHAR_R    = 8'h52;
  localparam logic [7:0] CHAR_W    = 8'h57;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_R_LC = 8'h72;
  localparam logic [7:0] CHAR_W_LC = 8'h77;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    TERM = 2'd3
  } state_t;

  function automatic logic is_term(input logic [7:0] b);
    return (b == CHAR_CR) || (b == CHAR_LF);
  endfunction

endpackage

// File: rtl/uart_bridge_rx_if.sv
// -----------------------------------------------------------------------------
// uart_bridge_rx_if
// Byte input and bus-transaction output of the UART bridge.
//   data_i/valid_i                         : received byte stream
//   addr_o/data_o/rw_o/valid_o/error_o     : decoded transaction + error strobe
// Modports: master = byte source / bus sink, slave = the bridge itself.
// -----------------------------------------------------------------------------
interface uart_bridge_rx_if;
  import bridge_pkg::*;

  logic [7:0]            data_i;
  logic                  valid_i;
  logic [BUS_ADDR_W-1:0] addr_o;
  logic [BUS_DATA_W-1:0] data_o;
  logic                  rw_o;
  logic                  valid_o;
  logic                  error_o;

  modport master (
    output data_i, valid_i,
    input  addr_o, data_o, rw_o, valid_o, error_o
  );

  modport slave (
    input  data_i, valid_i,
    output addr_o, data_o, rw_o, valid_o, error_o
  );

endinterface

// File: rtl/uart_bridge_rx_hex_decode.sv
// -----------------------------------------------------------------------------
// hex_decode
// Combinational ASCII hex digit decoder.
//   i_byte   in  8  ASCII byte
//   o_nibble out 4  decoded value (0 when not a hex digit)
//   o_is_hex out 1  byte is an accepted hex digit
// Macro UART_BRIDGE_RX_LOWERCASE_EN: when defined, 'a'-'f' are also accepted.
// -----------------------------------------------------------------------------
module hex_decode (
  input  logic [7:0] i_byte,
  output logic [3:0] o_nibble,
  output logic       o_is_hex
);

  // Letters A-F (and a-f) have low nibble 1..6, so adding 9 yields 10..15.
  always_comb begin
    o_nibble = 4'h0;
    o_is_hex = 1'b0;
    if ((i_byte >= 8'h30) && (i_byte <= 8'h39)) begin
      o_nibble = i_byte[3:0];
      o_is_hex = 1'b1;
    end else if ((i_byte >= 8'h41) && (i_byte <= 8'h46)) begin
      o_nibble = i_byte[3:0] + 4'h9;
      o_is_hex = 1'b1;
`ifdef UART_BRIDGE_RX_LOWERCASE_EN
    end else if ((i_byte >= 8'h61) && (i_byte <= 8'h66)) begin
      o_nibble = i_byte[3:0] + 4'h9;
      o_is_hex = 1'b1;
`endif
    end else begin
      o_nibble = 4'h0;
      o_is_hex = 1'b0;
    end
  end

endmodule

// File: rtl/uart_bridge_rx.sv
// -----------------------------------------------------------------------------
// uart_bridge_rx
// Parses "R"+4 hex+CR/LF (read) and "W"+4 hex addr+4 hex data+CR/LF (write)
// into single-cycle bus transactions.
//   clk  in  bus clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of uart_bridge_rx_if (byte in, transaction out)
// Parameter TIMEOUT_CYCLES: idle cycles before a partial message is dropped
// (0 disables the timeout).
// Macro UART_BRIDGE_RX_LOWERCASE_EN: accept lowercase hex digits and r/w.
// -----------------------------------------------------------------------------
module uart_bridge_rx
  import bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  uart_bridge_rx_if.slave   bus
);

  state_t                r_state, w_state_nxt;
  logic                  r_is_write, w_is_write_nxt;
  logic [3:0]            r_digit_cnt, w_digit_cnt_nxt;
  logic [31:0]           r_shift, w_shift_nxt;
  logic [31:0]           r_tmo_cnt, w_tmo_cnt_nxt;
  logic [BUS_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [BUS_DATA_W-1:0] r_data, w_data_nxt;
  logic                  r_rw, w_rw_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_error, w_error_nxt;

  logic [3:0]            w_nibble;
  logic                  w_is_hex;
  logic                  w_is_cmd_r;
  logic                  w_is_cmd_w;

  hex_decode u_hex_decode (
    .i_byte   (bus.data_i),
    .o_nibble (w_nibble),
    .o_is_hex (w_is_hex)
  );

`ifdef UART_BRIDGE_RX_LOWERCASE_EN
  assign w_is_cmd_r = (bus.data_i == CHAR_R) || (bus.data_i == CHAR_R_LC);
  assign w_is_cmd_w = (bus.data_i == CHAR_W) || (bus.data_i == CHAR_W_LC);
`else
  assign w_is_cmd_r = (bus.data_i == CHAR_R);
  assign w_is_cmd_w = (bus.data_i == CHAR_W);
`endif

  // Next-state, buffer, counters and output strobes.
  // The digit count runs 0..8 across address and data; after 4 digits the
  // address sits in shift[15:0] (read), after 8 it sits in shift[31:16] (write).
  always_comb begin
    w_state_nxt     = r_state;
    w_is_write_nxt  = r_is_write;
    w_digit_cnt_nxt = r_digit_cnt;
    w_shift_nxt     = r_shift;
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_rw_nxt        = r_rw;
    w_valid_nxt     = 1'b0;
    w_error_nxt     = 1'b0;

    if (bus.valid_i) begin
      // A byte always wins over a timeout expiring in the same cycle.
      w_tmo_cnt_nxt = 32'd0;
      if (w_is_cmd_r || w_is_cmd_w) begin
        // Command letter: start a new message; mid-message this is a resync.
        w_error_nxt     = (r_state != IDLE);
        w_state_nxt     = ADDR;
        w_is_write_nxt  = w_is_cmd_w;
        w_digit_cnt_nxt = 4'd0;
        w_shift_nxt     = 32'd0;
      end else begin
        case (r_state)
          IDLE: begin
            w_state_nxt = IDLE;
          end
          ADDR, DATA: begin
            if (w_is_hex) begin
              w_shift_nxt     = {r_shift[27:0], w_nibble};
              w_digit_cnt_nxt = r_digit_cnt + 4'd1;
              if ((r_state == ADDR) && (r_digit_cnt == 4'd3)) begin
                w_state_nxt = r_is_write ? DATA : TERM;
              end else if ((r_state == DATA) && (r_digit_cnt == 4'd7)) begin
                w_state_nxt = TERM;
              end else begin
                w_state_nxt = r_state;
              end
            end else begin
              w_error_nxt     = 1'b1;
              w_state_nxt     = IDLE;
              w_digit_cnt_nxt = 4'd0;
            end
          end
          TERM: begin
            if (is_term(bus.data_i)) begin
              w_valid_nxt = 1'b1;
              w_rw_nxt    = r_is_write;
              if (r_is_write) begin
                w_addr_nxt = r_shift[31:16];
                w_data_nxt = r_shift[15:0];
              end else begin
                w_addr_nxt = r_shift[15:0];
                w_data_nxt = 16'h0000;
              end
            end else begin
              w_error_nxt = 1'b1;
            end
            w_state_nxt     = IDLE;
            w_digit_cnt_nxt = 4'd0;
          end
          default: begin
            w_state_nxt     = IDLE;
            w_digit_cnt_nxt = 4'd0;
          end
        endcase
      end
    end else if ((TIMEOUT_CYCLES > 0) && (r_state != IDLE)) begin
      // Counter value N-1 on an idle cycle means this is the Nth idle cycle.
      if (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        w_error_nxt     = 1'b1;
        w_state_nxt     = IDLE;
        w_digit_cnt_nxt = 4'd0;
        w_tmo_cnt_nxt   = 32'd0;
      end else begin
        w_tmo_cnt_nxt = r_tmo_cnt + 32'd1;
      end
    end else begin
      w_tmo_cnt_nxt = 32'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_is_write  <= 1'b0;
      r_digit_cnt <= 4'd0;
      r_shift     <= 32'd0;
      r_tmo_cnt   <= 32'd0;
      r_addr      <= 16'h0000;
      r_data      <= 16'h0000;
      r_rw        <= 1'b0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_write  <= w_is_write_nxt;
      r_digit_cnt <= w_digit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_rw        <= w_rw_nxt;
      r_valid     <= w_valid_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign bus.addr_o  = r_addr;
  assign bus.data_o  = r_data;
  assign bus.rw_o    = r_rw;
  assign bus.valid_o = r_valid;
  assign bus.error_o = r_error;

endmodule
